// File: rtl/ddr4_rcd_ca_pipe.sv
// RDIMM register clock driver model for the DDR4 simulation wrappers. It registers the CA bus,
// masks column addresses, checks CA parity with an ALERT_n pulse, and sequences model_enable.
module ddr4_rcd_ca_pipe #(
    parameter int unsigned       RANKS       = 1,
    parameter int unsigned       ADDR_W      = 17,
    parameter int unsigned       BG_W        = 1,
    parameter int unsigned       BA_W        = 2,
    parameter int unsigned       CA_LATENCY  = 1,
    parameter logic [ADDR_W-1:0] COL_MASK    = 17'h1C7FF,
    parameter bit                PAR_EN      = 1'b1,
    parameter int unsigned       ALERT_PULSE = 4,
    parameter int unsigned       EN_DELAY    = 8
) (
    input  logic              c0_ddr4_ck_t,
    input  logic              c0_ddr4_reset_n,
    input  logic              c0_ddr4_act_n,
    input  logic [ADDR_W-1:0] c0_ddr4_adr,
    input  logic [BA_W-1:0]   c0_ddr4_ba,
    input  logic [BG_W-1:0]   c0_ddr4_bg,
    input  logic [RANKS-1:0]  c0_ddr4_cs_n,
    input  logic [RANKS-1:0]  c0_ddr4_cke,
    input  logic [RANKS-1:0]  c0_ddr4_odt,
    input  logic              c0_ddr4_par,
    output logic              q_act_n,
    output logic [ADDR_W-1:0] q_adr,
    output logic [BA_W-1:0]   q_ba,
    output logic [BG_W-1:0]   q_bg,
    output logic [RANKS-1:0]  q_cs_n,
    output logic [RANKS-1:0]  q_cke,
    output logic [RANKS-1:0]  q_odt,
    output logic              model_enable,
    output logic              alert_n,
    output logic [7:0]        par_err_cnt
);

    localparam int unsigned AW = (ALERT_PULSE < 1) ? 1 : $clog2(ALERT_PULSE + 1);
    localparam int unsigned EW = (EN_DELAY < 1) ? 1 : $clog2(EN_DELAY + 1);

    typedef struct packed {
        logic              act_n;
        logic [ADDR_W-1:0] adr;
        logic [BA_W-1:0]   ba;
        logic [BG_W-1:0]   bg;
        logic [RANKS-1:0]  cs_n;
        logic [RANKS-1:0]  cke;
        logic [RANKS-1:0]  odt;
        logic              perr;
    } ca_t;

    localparam ca_t C_IDLE = '{act_n: 1'b1, adr: '0, ba: '0, bg: '0,
                               cs_n: '1, cke: '0, odt: '0, perr: 1'b0};

    typedef enum logic {ST_WAIT, ST_ENABLED} en_state_t;

    logic [2:0]    w_cmd;
    logic          w_is_col;
    logic          w_sel;
    ca_t           w_stage_in;
    logic          w_perr_arrive;
    ca_t           w_out;
    ca_t           r_pipe [CA_LATENCY];
    logic [AW-1:0] r_alert_cnt;
    logic [7:0]    r_err_cnt;
    en_state_t     r_state;
    en_state_t     w_state_next;
    logic [EW-1:0] r_en_cnt;
    logic [EW-1:0] w_en_cnt_next;

    // RAS/CAS/WE live on A16:A14; the shift keeps narrow address buses legal.
    assign w_cmd    = 3'(c0_ddr4_adr >> 14);
    assign w_is_col = c0_ddr4_act_n & ((w_cmd == 3'b100) | (w_cmd == 3'b101));
    assign w_sel    = ~&c0_ddr4_cs_n;

    always_comb begin
        w_stage_in       = C_IDLE;
        w_stage_in.act_n = c0_ddr4_act_n;
        w_stage_in.adr   = w_is_col ? (c0_ddr4_adr & COL_MASK) : c0_ddr4_adr;
        w_stage_in.ba    = c0_ddr4_ba;
        w_stage_in.bg    = c0_ddr4_bg;
        w_stage_in.cs_n  = c0_ddr4_cs_n;
        w_stage_in.cke   = c0_ddr4_cke;
        w_stage_in.odt   = c0_ddr4_odt;
        w_stage_in.perr  = PAR_EN & w_sel &
                           ((^{c0_ddr4_act_n, c0_ddr4_adr, c0_ddr4_bg, c0_ddr4_ba}) != c0_ddr4_par);
    end

    always_ff @(posedge c0_ddr4_ck_t or negedge c0_ddr4_reset_n) begin
        if (!c0_ddr4_reset_n) begin
            for (int unsigned i = 0; i < CA_LATENCY; i++) r_pipe[i] <= C_IDLE;
        end else begin
            r_pipe[0] <= w_stage_in;
            for (int unsigned i = 1; i < CA_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    // Alert and error count update on the edge the errored command lands in the output stage.
    generate
        if (CA_LATENCY == 1) begin : g_arrive_direct
            assign w_perr_arrive = w_stage_in.perr;
        end else begin : g_arrive_pipe
            assign w_perr_arrive = r_pipe[CA_LATENCY-2].perr;
        end
    endgenerate

    always_ff @(posedge c0_ddr4_ck_t or negedge c0_ddr4_reset_n) begin
        if (!c0_ddr4_reset_n) begin
            r_alert_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_perr_arrive) begin
                r_alert_cnt <= AW'(ALERT_PULSE);
            end else if (r_alert_cnt != '0) begin
                r_alert_cnt <= r_alert_cnt - 1'b1;
            end
            if (w_perr_arrive && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge c0_ddr4_ck_t or negedge c0_ddr4_reset_n) begin
        if (!c0_ddr4_reset_n) begin
            r_state  <= ST_WAIT;
            r_en_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_en_cnt <= w_en_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_en_cnt_next = r_en_cnt;
        model_enable  = 1'b0;
        case (r_state)
            ST_WAIT: begin
                w_en_cnt_next = r_en_cnt + 1'b1;
                if (r_en_cnt == EW'(EN_DELAY - 1)) w_state_next = ST_ENABLED;
            end
            ST_ENABLED: model_enable = 1'b1;
            default:    w_state_next = ST_WAIT;
        endcase
    end

    assign w_out       = r_pipe[CA_LATENCY-1];
    assign q_act_n     = w_out.act_n;
    assign q_adr       = w_out.adr;
    assign q_ba        = w_out.ba;
    assign q_bg        = w_out.bg;
    assign q_cs_n      = w_out.perr ? '1 : w_out.cs_n;
    assign q_cke       = w_out.cke;
    assign q_odt       = w_out.odt;
    assign alert_n     = (r_alert_cnt == '0);
    assign par_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_ddr4_rcd_ca_pipe.sv
// Scoreboard bench for ddr4_rcd_ca_pipe: two instances share the CA stimulus, one with parity
// checking and two-stage latency, one with parity disabled and single-stage latency.
module tb_ddr4_rcd_ca_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        act_n;
    logic [16:0] adr;
    logic [1:0]  ba;
    logic [0:0]  bg;
    logic [1:0]  cs_n, cke, odt;
    logic        par;

    logic        o0_act_n, o1_act_n;
    logic [16:0] o0_adr, o1_adr;
    logic [1:0]  o0_ba, o1_ba;
    logic [0:0]  o0_bg, o1_bg;
    logic [1:0]  o0_cs_n, o1_cs_n, o0_cke, o1_cke, o0_odt, o1_odt;
    logic        o0_me, o1_me, o0_alert_n, o1_alert_n;
    logic [7:0]  o0_cnt, o1_cnt;

    always #5 clk = ~clk;

    ddr4_rcd_ca_pipe #(.RANKS(2), .CA_LATENCY(2), .PAR_EN(1'b1), .ALERT_PULSE(4), .EN_DELAY(8)) dut0 (
        .c0_ddr4_ck_t(clk), .c0_ddr4_reset_n(rst_n), .c0_ddr4_act_n(act_n), .c0_ddr4_adr(adr),
        .c0_ddr4_ba(ba), .c0_ddr4_bg(bg), .c0_ddr4_cs_n(cs_n), .c0_ddr4_cke(cke),
        .c0_ddr4_odt(odt), .c0_ddr4_par(par), .q_act_n(o0_act_n), .q_adr(o0_adr), .q_ba(o0_ba),
        .q_bg(o0_bg), .q_cs_n(o0_cs_n), .q_cke(o0_cke), .q_odt(o0_odt), .model_enable(o0_me),
        .alert_n(o0_alert_n), .par_err_cnt(o0_cnt));

    ddr4_rcd_ca_pipe #(.RANKS(2), .CA_LATENCY(1), .PAR_EN(1'b0), .ALERT_PULSE(4), .EN_DELAY(1)) dut1 (
        .c0_ddr4_ck_t(clk), .c0_ddr4_reset_n(rst_n), .c0_ddr4_act_n(act_n), .c0_ddr4_adr(adr),
        .c0_ddr4_ba(ba), .c0_ddr4_bg(bg), .c0_ddr4_cs_n(cs_n), .c0_ddr4_cke(cke),
        .c0_ddr4_odt(odt), .c0_ddr4_par(par), .q_act_n(o1_act_n), .q_adr(o1_adr), .q_ba(o1_ba),
        .q_bg(o1_bg), .q_cs_n(o1_cs_n), .q_cke(o1_cke), .q_odt(o1_odt), .model_enable(o1_me),
        .alert_n(o1_alert_n), .par_err_cnt(o1_cnt));

    typedef struct {
        int unsigned due;
        logic        act_n;
        logic [16:0] adr;
        logic [1:0]  ba;
        logic [0:0]  bg;
        logic [1:0]  cs_n, cke, odt;
        logic        alert_n;
        logic [7:0]  cnt;
        logic        me;
    } exp_t;

    exp_t        q0[$], q1[$];
    exp_t        m0, m1;
    int unsigned cyc;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned vn = 0;

    // Rising edges since the most recent reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (q0.size() != 0 && q0[0].due <= cyc) begin
                m0 = q0.pop_front();
                chk("d0_due", cyc, m0.due);
                chk("d0_act_n", o0_act_n, m0.act_n);
                chk("d0_adr", o0_adr, m0.adr);
                chk("d0_ba_bg", {o0_bg, o0_ba}, {m0.bg, m0.ba});
                chk("d0_cs_n", o0_cs_n, m0.cs_n);
                chk("d0_cke_odt", {o0_cke, o0_odt}, {m0.cke, m0.odt});
                chk("d0_alert_n", o0_alert_n, m0.alert_n);
                chk("d0_err_cnt", o0_cnt, m0.cnt);
                chk("d0_model_enable", o0_me, m0.me);
            end
            if (q1.size() != 0 && q1[0].due <= cyc) begin
                m1 = q1.pop_front();
                chk("d1_due", cyc, m1.due);
                chk("d1_act_n", o1_act_n, m1.act_n);
                chk("d1_adr", o1_adr, m1.adr);
                chk("d1_ba_bg", {o1_bg, o1_ba}, {m1.bg, m1.ba});
                chk("d1_cs_n", o1_cs_n, m1.cs_n);
                chk("d1_cke_odt", {o1_cke, o1_odt}, {m1.cke, m1.odt});
                chk("d1_alert_n", o1_alert_n, m1.alert_n);
                chk("d1_err_cnt", o1_cnt, m1.cnt);
                chk("d1_model_enable", o1_me, m1.me);
            end
        end
    end

    // Drives one CA beat; bad flips the parity bit. Expected values are for dut0 (latency 2);
    // dut1 sees the same address but no parity gating, alert or count.
    task automatic vec(input logic a, input logic [16:0] ad, input logic [1:0] cs, input logic bad,
                       input logic [16:0] x_adr, input logic [1:0] x_cs0, input logic x_alert,
                       input logic [7:0] x_cnt);
        exp_t e;
        @(negedge clk);
        vn++;
        act_n = a;
        adr   = ad;
        cs_n  = cs;
        ba    = vn[1:0];
        bg    = vn[2];
        cke   = vn[3:2];
        odt   = ~vn[1:0];
        par   = (^{a, ad, bg, ba}) ^ bad;
        e.due = cyc + 2; e.act_n = a; e.adr = x_adr; e.ba = ba; e.bg = bg;
        e.cs_n = x_cs0; e.cke = cke; e.odt = odt; e.alert_n = x_alert; e.cnt = x_cnt;
        e.me = (cyc + 2 >= 8);
        q0.push_back(e);
        e.due = cyc + 1; e.cs_n = cs; e.alert_n = 1'b1; e.cnt = 8'd0; e.me = 1'b1;
        q1.push_back(e);
    endtask

    task automatic idle(input int unsigned n, input logic x_alert, input logic [7:0] x_cnt);
        for (int unsigned i = 0; i < n; i++) vec(1'b1, 17'h0, 2'b11, 1'b0, 17'h0, 2'b11, x_alert, x_cnt);
    endtask

    task automatic reset_checks();
        chk("rst_cs_n", {o0_cs_n, o1_cs_n}, 4'hF);
        chk("rst_act_n", {o0_act_n, o1_act_n}, 2'b11);
        chk("rst_adr", o0_adr | o1_adr, 17'h0);
        chk("rst_fields", {o0_ba, o0_bg, o0_cke, o0_odt, o1_ba, o1_bg, o1_cke, o1_odt}, 18'h0);
        chk("rst_alert_n", {o0_alert_n, o1_alert_n}, 2'b11);
        chk("rst_err_cnt", {o0_cnt, o1_cnt}, 16'h0);
        chk("rst_model_enable", {o0_me, o1_me}, 2'b00);
    endtask

    initial begin
        act_n = 1'b0; adr = 17'h1FFFF; ba = 2'b11; bg = 1'b1;
        cs_n = 2'b00; cke = 2'b11; odt = 2'b11; par = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset_checks();
        @(negedge clk);
        act_n = 1'b1; adr = '0; cs_n = 2'b11; cke = '0; odt = '0; par = 1'b1;
        rst_n = 1'b1;

        idle(4, 1'b1, 8'd0);
        for (int i = 0; i < 4; i++) vec(1'b1, 17'h01234, 2'b11, 1'b1, 17'h01234, 2'b11, 1'b1, 8'd0);
        vec(1'b1, 17'h13FFF, 2'b10, 1'b0, 17'h107FF, 2'b10, 1'b1, 8'd0);
        vec(1'b1, 17'h0FFFF, 2'b10, 1'b0, 17'h0FFFF, 2'b10, 1'b1, 8'd0);
        vec(1'b0, 17'h1FFFF, 2'b10, 1'b0, 17'h1FFFF, 2'b10, 1'b1, 8'd0);
        vec(1'b1, 17'h15555, 2'b01, 1'b0, 17'h14555, 2'b01, 1'b1, 8'd0);
        vec(1'b0, 17'h13FFF, 2'b01, 1'b0, 17'h13FFF, 2'b01, 1'b1, 8'd0);
        vec(1'b1, 17'h1BFFF, 2'b00, 1'b0, 17'h1BFFF, 2'b00, 1'b1, 8'd0);
        vec(1'b1, 17'h13FFF, 2'b11, 1'b0, 17'h107FF, 2'b11, 1'b1, 8'd0);
        idle(2, 1'b1, 8'd0);

        vec(1'b1, 17'h00ABC, 2'b01, 1'b1, 17'h00ABC, 2'b11, 1'b0, 8'd1);
        idle(3, 1'b0, 8'd1);
        idle(2, 1'b1, 8'd1);

        vec(1'b1, 17'h00ABC, 2'b10, 1'b1, 17'h00ABC, 2'b11, 1'b0, 8'd2);
        idle(1, 1'b0, 8'd2);
        vec(1'b0, 17'h0F0F0, 2'b10, 1'b1, 17'h0F0F0, 2'b11, 1'b0, 8'd3);
        idle(3, 1'b0, 8'd3);
        idle(1, 1'b1, 8'd3);

        vec(1'b1, 17'h13FFF, 2'b00, 1'b1, 17'h107FF, 2'b11, 1'b0, 8'd4);
        idle(3, 1'b0, 8'd4);
        idle(1, 1'b1, 8'd4);

        for (int k = 1; k <= 300; k++)
            vec(1'b1, 17'(k), 2'b10, 1'b1, 17'(k), 2'b11, 1'b0, (k + 4 > 255) ? 8'd255 : 8'(k + 4));

        // Mid-pulse reset with errored commands still in flight.
        @(negedge clk);
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1 reset_checks();
        repeat (2) @(negedge clk);
        act_n = 1'b1; adr = '0; cs_n = 2'b11; cke = '0; odt = '0; par = 1'b1;
        rst_n = 1'b1;
        idle(10, 1'b1, 8'd0);

        for (int i = 0; i < 10 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
